dtmf_dial_sequencer: RTL

//  Queues keypad digits and plays each as a DTMF tone pair: a row tone and a column tone.

---
 rtl/dtmf_pkg.sv | 48 ++++
 rtl/dtmf_tone_div.sv | 41 ++++
 rtl/dtmf_dial_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF dial sequencer: FSM states, tone divisor tables
// and the keypad code to row/column lookup.
package dtmf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] DIGIT_STAR = 4'd14;
  localparam logic [3:0] DIGIT_HASH = 4'd15;

  // Half-period divisors in 1 MHz cycles, indexed by row (697..941 Hz) and column (1209..1633 Hz).
  localparam logic [9:0] ROW_DIV [4] = '{10'd717, 10'd649, 10'd587, 10'd531};
  localparam logic [9:0] COL_DIV [4] = '{10'd414, 10'd374, 10'd339, 10'd306};

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Keypad layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic key_pos_t key_pos(input logic [3:0] code);
    key_pos_t p;
    case (code)
      4'd1:       p = {2'd0, 2'd0};
      4'd2:       p = {2'd0, 2'd1};
      4'd3:       p = {2'd0, 2'd2};
      4'd10:      p = {2'd0, 2'd3};
      4'd4:       p = {2'd1, 2'd0};
      4'd5:       p = {2'd1, 2'd1};
      4'd6:       p = {2'd1, 2'd2};
      4'd11:      p = {2'd1, 2'd3};
      4'd7:       p = {2'd2, 2'd0};
      4'd8:       p = {2'd2, 2'd1};
      4'd9:       p = {2'd2, 2'd2};
      4'd12:      p = {2'd2, 2'd3};
      DIGIT_STAR: p = {2'd3, 2'd0};
      4'd0:       p = {2'd3, 2'd1};
      DIGIT_HASH: p = {2'd3, 2'd2};
      4'd13:      p = {2'd3, 2'd3};
      default:    p = {2'd3, 2'd1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dtmf_tone_div.sv
// Square-wave tone generator: toggles its output every half_div enabled cycles,
// restarting from a low output with a zero count whenever it is disabled.
module dtmf_tone_div (
  input  logic       clk_1m_in,
  input  logic       reset_b,
  input  logic       en,
  input  logic [9:0] half_div,
  output logic       tone_out
);

  logic [9:0] count_q, count_d;
  logic       tone_q, tone_d;

  always_comb begin
    count_d = count_q;
    tone_d  = tone_q;
    if (!en) begin
      count_d = 10'd0;
      tone_d  = 1'b0;
    end else if (count_q == (half_div - 10'd1)) begin
      count_d = 10'd0;
      tone_d  = ~tone_q;
    end else begin
      count_d = count_q + 10'd1;
      tone_d  = tone_q;
    end
  end

  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      count_q <= 10'd0;
      tone_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tone_q  <= tone_d;
    end
  end

  assign tone_out = tone_q;

endmodule

// File: rtl/dtmf_dial_sequencer.sv
// Digit queue plus IDLE/TONE/GAP sequencer that plays each queued keypad code as a
// row/column tone burst followed by a silent gap.
module dtmf_dial_sequencer
  import dtmf_pkg::*;
#(
  parameter int TONE_CYCLES = 100000,
  parameter int GAP_CYCLES  = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_1m_in,
  input  logic       reset_b,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       abort,
  output logic       tone_row_out,
  output logic       tone_col_out,
  output logic       tone_active,
  output logic       busy,
  output logic [2:0] digits_pending
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DUR_W = 17;

  localparam logic [DUR_W-1:0] TONE_LAST = DUR_W'(TONE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = {DUR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [3:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [9:0]       row_div_q, row_div_d;
  logic [9:0]       col_div_q, col_div_d;

  logic             full_s, empty_s, push_s, pop_s, tone_en_s;
  key_pos_t         head_pos_s;

  assign full_s      = (count_q == CNT_FULL);
  assign empty_s     = (count_q == {CNT_W{1'b0}});
  assign digit_ready = !full_s && !abort;
  assign push_s      = digit_valid && digit_ready;
  // The head is only taken from IDLE, so a freshly pushed digit waits one cycle in the queue.
  assign pop_s       = (state_q == ST_IDLE) && !empty_s && !abort;
  assign head_pos_s  = key_pos(fifo_q[rd_ptr_q]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 4'd0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= digit_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    row_div_d = row_div_q;
    col_div_d = col_div_q;
    if (abort) begin
      state_d   = ST_IDLE;
      dur_d     = {DUR_W{1'b0}};
      row_div_d = 10'd0;
      col_div_d = 10'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            state_d   = ST_TONE;
            row_div_d = ROW_DIV[head_pos_s.row];
            col_div_d = COL_DIV[head_pos_s.col];
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_TONE: begin
          if (dur_q == TONE_LAST) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_TONE;
          end
        end
        ST_GAP: begin
          if (dur_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Duration counter restarts on every state entry and saturates rather than wrapping.
      if (state_d != state_q) begin
        dur_d = {DUR_W{1'b0}};
      end else if (dur_q != DUR_MAX) begin
        dur_d = dur_q + DUR_W'(1);
      end else begin
        dur_d = dur_q;
      end
    end
  end

  always_ff @(posedge clk_1m_in or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= ST_IDLE;
      dur_q     <= {DUR_W{1'b0}};
      row_div_q <= 10'd0;
      col_div_q <= 10'd0;
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      row_div_q <= row_div_d;
      col_div_q <= col_div_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Dividers run only while staying in TONE, so they are already cleared on the exit edge.
  assign tone_en_s = (state_q == ST_TONE) && (state_d == ST_TONE);

  dtmf_tone_div u_row_div (
    .clk_1m_in (clk_1m_in),
    .reset_b   (reset_b),
    .en        (tone_en_s),
    .half_div  (row_div_q),
    .tone_out  (tone_row_out)
  );

  dtmf_tone_div u_col_div (
    .clk_1m_in (clk_1m_in),
    .reset_b   (reset_b),
    .en        (tone_en_s),
    .half_div  (col_div_q),
    .tone_out  (tone_col_out)
  );

  assign tone_active    = (state_q == ST_TONE);
  assign busy           = (state_q != ST_IDLE) || !empty_s;
  assign digits_pending = 3'(count_q);

endmodule
